// File: rtl/tile_match_pkg.sv
// Shared types and helpers for the tile-matching round controller.
package tile_match_pkg;

  localparam int TILE_IDX_W  = 4;
  localparam int COLOR_W_DEF = 4;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_WAIT_FIRST  = 3'd1;
  localparam logic [2:0] ST_HOLD_FIRST  = 3'd2;
  localparam logic [2:0] ST_WAIT_SECOND = 3'd3;
  localparam logic [2:0] ST_SHOW_BOTH   = 3'd4;
  localparam logic [2:0] ST_RESOLVE     = 3'd5;
  localparam logic [2:0] ST_DONE        = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE        = ST_IDLE,
    S_WAIT_FIRST  = ST_WAIT_FIRST,
    S_HOLD_FIRST  = ST_HOLD_FIRST,
    S_WAIT_SECOND = ST_WAIT_SECOND,
    S_SHOW_BOTH   = ST_SHOW_BOTH,
    S_RESOLVE     = ST_RESOLVE,
    S_DONE        = ST_DONE
  } state_e;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd2_inc_sat(input logic [7:0] bcd);
    if (bcd == 8'h99)       return 8'h99;
    if (bcd[3:0] == 4'd9)   return {bcd[7:4] + 4'd1, 4'd0};
    return {bcd[7:4], bcd[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/round_timer.sv
// Loadable down-counter shared by all timed states; expire is high while the count is 0.
module round_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - 1'b1;
  end

  assign expire = (count == '0);

endmodule

// File: rtl/match_round_controller.sv
// Sequences one tile-matching round: picks, settle/reveal timing, compare, BCD move count.
// Optional build macro PICK_TIMEOUT_EN adds a second-pick timeout in WAIT_SECOND.
module match_round_controller
  import tile_match_pkg::*;
#(
  parameter int NUM_TILES      = 10,
  parameter int COLOR_W        = COLOR_W_DEF,
  parameter int SETTLE_CYCLES  = 25_000_000,
  parameter int SHOW_CYCLES    = 100_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         quit,
  input  logic                         pick_valid,
  input  logic [TILE_IDX_W-1:0]        pick_idx,
  output logic                         pick_ready,
  input  logic [NUM_TILES*COLOR_W-1:0] tile_colors,
  output logic [NUM_TILES-1:0]         matched_mask,
  output logic [NUM_TILES-1:0]         shown_mask,
  output logic [COLOR_W-1:0]           first_color,
  output logic [COLOR_W-1:0]           second_color,
  output logic                         show_first,
  output logic                         show_second,
  output logic [7:0]                   moves_bcd,
  output logic                         match_pulse,
  output logic                         miss_pulse,
  output logic                         reject_pulse,
  output logic                         game_over,
  output logic [2:0]                   state_dbg
);

  localparam int MAX_SS  = (SETTLE_CYCLES > SHOW_CYCLES) ? SETTLE_CYCLES : SHOW_CYCLES;
  localparam int MAX_CYC = (TIMEOUT_CYCLES > MAX_SS) ? TIMEOUT_CYCLES : MAX_SS;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // The timer loads N-1 on entry so the state lasts N cycles; 0 collapses to 1.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] SHOW_LOAD   = CNT_W'((SHOW_CYCLES > 1) ? SHOW_CYCLES - 1 : 0);
`ifdef PICK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LOAD    = CNT_W'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0);
`endif

  // Out-of-range indices shift the single bit off the top and yield an empty mask.
  function automatic logic [NUM_TILES-1:0] tile_bit(input logic [TILE_IDX_W-1:0] idx);
    return NUM_TILES'(1) << idx;
  endfunction

  state_e                  state, state_nxt;
  logic [TILE_IDX_W-1:0]   first_idx, second_idx;
  logic [NUM_TILES-1:0]    pick_oh, resolved_mask;
  logic [COLOR_W-1:0]      pick_color;
  logic                    pick_fire, pick_illegal, colors_equal;
  logic                    timer_load, timer_expire;
  logic [CNT_W-1:0]        timer_val;
  logic                    accept_first, accept_second, do_resolve, timed_out, new_game;

  assign pick_ready   = (state == S_WAIT_FIRST) || (state == S_WAIT_SECOND);
  assign pick_fire    = pick_valid && pick_ready;
  assign pick_oh      = tile_bit(pick_idx);
  assign pick_color   = tile_colors[int'(pick_idx)*COLOR_W +: COLOR_W];
  assign pick_illegal = (pick_oh == '0) || (|(pick_oh & matched_mask)) ||
                        ((state == S_WAIT_SECOND) && (pick_idx == first_idx));
  assign colors_equal  = (first_color == second_color);
  assign resolved_mask = matched_mask |
                         (colors_equal ? (tile_bit(first_idx) | tile_bit(second_idx)) : '0);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt     = state;
    timer_load    = 1'b0;
    timer_val     = '0;
    accept_first  = 1'b0;
    accept_second = 1'b0;
    do_resolve    = 1'b0;
    timed_out     = 1'b0;
    new_game      = 1'b0;
    if (quit) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: if (start) begin
          state_nxt = S_WAIT_FIRST;
          new_game  = 1'b1;
        end
        S_WAIT_FIRST: if (pick_fire && !pick_illegal) begin
          state_nxt    = S_HOLD_FIRST;
          accept_first = 1'b1;
          timer_load   = 1'b1;
          timer_val    = SETTLE_LOAD;
        end
        S_HOLD_FIRST: if (timer_expire) begin
          state_nxt = S_WAIT_SECOND;
`ifdef PICK_TIMEOUT_EN
          timer_load = 1'b1;
          timer_val  = TMO_LOAD;
`endif
        end
        S_WAIT_SECOND: begin
          if (pick_fire && !pick_illegal) begin
            state_nxt     = S_SHOW_BOTH;
            accept_second = 1'b1;
            timer_load    = 1'b1;
            timer_val     = SHOW_LOAD;
          end
`ifdef PICK_TIMEOUT_EN
          else if (timer_expire && !pick_fire) begin
            state_nxt = S_WAIT_FIRST;
            timed_out = 1'b1;
          end
`endif
        end
        S_SHOW_BOTH: if (timer_expire) state_nxt = S_RESOLVE;
        S_RESOLVE: begin
          do_resolve = 1'b1;
          state_nxt  = (resolved_mask == '1) ? S_DONE : S_WAIT_FIRST;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: all control and datapath registers are reset so outputs are defined straight out of reset.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      first_idx    <= '0;
      second_idx   <= '0;
      first_color  <= '0;
      second_color <= '0;
      show_first   <= 1'b0;
      show_second  <= 1'b0;
      matched_mask <= '0;
      moves_bcd    <= 8'h00;
      reject_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      reject_pulse <= pick_fire && pick_illegal && !quit;
      if (quit) begin
        show_first   <= 1'b0;
        show_second  <= 1'b0;
        matched_mask <= '0;
      end else begin
        if (new_game) begin
          matched_mask <= '0;
          moves_bcd    <= 8'h00;
          show_first   <= 1'b0;
          show_second  <= 1'b0;
        end
        if (accept_first) begin
          first_idx   <= pick_idx;
          first_color <= pick_color;
          show_first  <= 1'b1;
        end
        if (accept_second) begin
          second_idx   <= pick_idx;
          second_color <= pick_color;
          show_second  <= 1'b1;
        end
        if (do_resolve) begin
          moves_bcd    <= bcd2_inc_sat(moves_bcd);
          matched_mask <= resolved_mask;
          show_first   <= 1'b0;
          show_second  <= 1'b0;
        end
        if (timed_out) begin
          moves_bcd  <= bcd2_inc_sat(moves_bcd);
          show_first <= 1'b0;
        end
      end
    end
  end

  round_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .load     (timer_load),
    .load_val (timer_val),
    .expire   (timer_expire)
  );

  assign shown_mask  = matched_mask | (show_first  ? tile_bit(first_idx)  : '0)
                                    | (show_second ? tile_bit(second_idx) : '0);
  assign match_pulse = do_resolve && colors_equal;
  assign miss_pulse  = (do_resolve && !colors_equal) || timed_out;
  assign game_over   = (state == S_DONE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_match_round_controller.sv
// Directed self-checking bench for match_round_controller (SETTLE=3, SHOW=5, TIMEOUT=20).
module tb_match_round_controller;

  localparam int NT = 10;
  localparam int CW = 4;
  localparam logic [2:0] IDLE = 3'd0, WF = 3'd1, HOLD = 3'd2, WS = 3'd3,
                         SHOW = 3'd4, RES = 3'd5, DONE = 3'd6;

  logic            CLOCK_50 = 1'b0;
  logic            resetn, start, quit, pick_valid;
  logic [3:0]      pick_idx;
  logic            pick_ready;
  logic [NT*CW-1:0] tile_colors;
  logic [NT-1:0]   matched_mask, shown_mask;
  logic [CW-1:0]   first_color, second_color;
  logic            show_first, show_second, match_pulse, miss_pulse, reject_pulse, game_over;
  logic [7:0]      moves_bcd;
  logic [2:0]      state_dbg;

  logic [CW-1:0]   colors [NT];
  logic [NT-1:0]   exp_mask;
  int              moves_dec;
  int              n_checks = 0;
  int              n_fail   = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  always_comb begin
    tile_colors = '0;
    for (int i = 0; i < NT; i++) tile_colors[i*CW +: CW] = colors[i];
  end

  match_round_controller #(
    .NUM_TILES(NT), .COLOR_W(CW), .SETTLE_CYCLES(3), .SHOW_CYCLES(5), .TIMEOUT_CYCLES(20)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .quit(quit),
    .pick_valid(pick_valid), .pick_idx(pick_idx), .pick_ready(pick_ready),
    .tile_colors(tile_colors), .matched_mask(matched_mask), .shown_mask(shown_mask),
    .first_color(first_color), .second_color(second_color),
    .show_first(show_first), .show_second(show_second), .moves_bcd(moves_bcd),
    .match_pulse(match_pulse), .miss_pulse(miss_pulse), .reject_pulse(reject_pulse),
    .game_over(game_over), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [7:0] exp_bcd();
    logic [7:0] r;
    r[7:4] = 4'(moves_dec / 10);
    r[3:0] = 4'(moves_dec % 10);
    return r;
  endfunction

  task automatic pick(input logic [3:0] idx);
    pick_valid = 1'b1;
    pick_idx   = idx;
    tick();
    pick_valid = 1'b0;
  endtask

  // From WAIT_FIRST: first pick, then the 3-cycle settle window.
  task automatic first_half(input int a);
    check("wf_state", state_dbg, WF);
    check("wf_ready", pick_ready, 1);
    pick(4'(a));
    check("hold_state", state_dbg, HOLD);
    check("first_color", first_color, colors[a]);
    check("shown_first", shown_mask, exp_mask | (NT'(1) << a));
    tick(); tick();
    check("hold_ready", pick_ready, 0);
    tick();
    check("ws_ready", pick_ready, 1);
  endtask

  // From WAIT_SECOND: second pick, 5-cycle reveal, resolve, model update.
  task automatic second_half(input int a, input int b);
    logic eq;
    eq = (colors[a] == colors[b]);
    pick(4'(b));
    check("show_state", state_dbg, SHOW);
    check("second_color", second_color, colors[b]);
    check("shown_both", shown_mask, exp_mask | (NT'(1) << a) | (NT'(1) << b));
    repeat (4) tick();
    check("show_last", state_dbg, SHOW);
    check("early_match", match_pulse, 0);
    tick();
    check("res_state", state_dbg, RES);
    check("match_pulse", match_pulse, eq);
    check("miss_pulse", miss_pulse, !eq);
    if (eq) exp_mask = exp_mask | (NT'(1) << a) | (NT'(1) << b);
    if (moves_dec < 99) moves_dec++;
    tick();
    check("matched_mask", matched_mask, exp_mask);
    check("moves_bcd", moves_bcd, exp_bcd());
    check("shown_back", shown_mask, exp_mask);
    check("post_state", state_dbg, (exp_mask == '1) ? DONE : WF);
    check("pulse_clear", match_pulse | miss_pulse, 0);
  endtask

  task automatic do_round(input int a, input int b);
    first_half(a);
    second_half(a, b);
  endtask

  initial begin
    resetn = 1'b1; start = 0; quit = 0; pick_valid = 0; pick_idx = '0;
    colors = '{4'd1, 4'd4, 4'd2, 4'd4, 4'd5, 4'd3, 4'd5, 4'd1, 4'd6, 4'd6};
    exp_mask = '0; moves_dec = 0;
    #2 resetn = 1'b0;
    tick(); tick();
    check("rst_state", state_dbg, IDLE);
    check("rst_masks", {matched_mask, shown_mask}, 0);
    check("rst_moves", moves_bcd, 0);
    check("rst_flags", {show_first, show_second, game_over, pick_ready, reject_pulse}, 0);
    check("rst_colors", {first_color, second_color}, 0);
    resetn = 1'b1;
    tick();

    // 1: equal colours (0,7)
    start = 1; tick(); start = 0;
    do_round(0, 7);
    check("t1_mask", matched_mask, 10'h081);
    check("t1_moves", moves_bcd, 8'h01);

    // 2: differing colours (2,5)
    do_round(2, 5);
    check("t2_mask", matched_mask, 10'h081);

    // 3: illegal picks
    pick(4'd1);
    check("t3_hold", state_dbg, HOLD);
    pick_valid = 1; pick_idx = 4'd3;
    check("t3_hold_ready", pick_ready, 0);
    tick(); pick_valid = 0;
    tick(); tick();
    check("t3_ws", state_dbg, WS);
    check("t3_hold_ignored", show_second, 0);
    foreach (colors[k]) if (k == 0) begin end
    for (int i = 0; i < 3; i++) begin
      pick((i == 0) ? 4'd1 : (i == 1) ? 4'd12 : 4'd0);
      check("t3_reject", reject_pulse, 1);
      check("t3_state_kept", state_dbg, WS);
    end
    tick();
    check("t3_reject_clear", reject_pulse, 0);
    second_half(1, 3);

    // 4: finish the board
    colors[5] = 4'd2;
    do_round(4, 6);
    do_round(8, 9);
    do_round(2, 5);
    check("t4_game_over", game_over, 1);
    check("t4_done", state_dbg, DONE);
    check("t4_done_ready", pick_ready, 0);
    start = 1; tick(); start = 0;
    exp_mask = '0; moves_dec = 0;
    check("t4_restart_state", state_dbg, WF);
    check("t4_restart_mask", matched_mask, 0);
    check("t4_restart_moves", moves_bcd, 8'h00);
    check("t4_restart_go", game_over, 0);

    // 5: BCD carry and saturation via repeated misses
    for (int r = 1; r <= 100; r++) begin
      do_round(0, 1);
      if (r == 9)  check("t5_bcd09", moves_bcd, 8'h09);
      if (r == 10) check("t5_bcd10", moves_bcd, 8'h10);
    end
    check("t5_bcd_sat", moves_bcd, 8'h99);

    // 6: quit during SHOW_BOTH, then reset mid-round
    do_round(0, 7);
    first_half(2);
    pick(4'd4);
    tick();
    quit = 1; start = 1; tick(); quit = 0; start = 0;
    exp_mask = '0;
    check("t6_quit_state", state_dbg, IDLE);
    check("t6_quit_show", {show_first, show_second}, 0);
    check("t6_quit_masks", {matched_mask, shown_mask}, 0);
    check("t6_quit_moves", moves_bcd, 8'h99);
    start = 1; tick(); start = 0;
    pick(4'd2);
    #3 resetn = 1'b0;
    #1;
    check("t6_rst_state", state_dbg, IDLE);
    check("t6_rst_outs", {matched_mask, shown_mask, show_first, show_second, game_over}, 0);
    check("t6_rst_moves", {moves_bcd, first_color}, 0);
    tick();
    resetn = 1'b1;
    moves_dec = 0;

`ifdef PICK_TIMEOUT_EN
    tick();
    start = 1; tick(); start = 0;
    first_half(0);
    repeat (19) tick();
    check("tmo_state", state_dbg, WS);
    check("tmo_miss", miss_pulse, 1);
    check("tmo_moves_before", moves_bcd, 8'h00);
    tick();
    check("tmo_wf", state_dbg, WF);
    check("tmo_moves", moves_bcd, 8'h01);
    check("tmo_show", show_first, 0);
    check("tmo_pulse_clear", miss_pulse, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
